// File: rtl/st_ctrl_pkg.sv
// ============================================================================
// Module      : st_ctrl_pkg
// Description : Shared opcodes, state encoding and fault codes for the store
//               sequencer, plus the byte-mask to bit-mask expansion helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package st_ctrl_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC0  = 3'd1,
        ACC1  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } st_state_e;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b01;
    localparam logic [1:0] FLT_MISALIGN = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    function automatic logic [31:0] expand_mask(input logic [3:0] byte_mask);
        logic [31:0] bits;
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{byte_mask[i]}};
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/st_lane_align.sv
// ============================================================================
// Module      : st_lane_align
// Description : Combinational lane steering for SB/SH/SW: rotates store data
//               into byte lanes and builds per-bit masks for both words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module st_lane_align
    import st_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [31:0] wrbits0,
    output logic [31:0] wrbits1,
    output logic        misaligned
);

    logic [3:0] w_base;
    logic [6:0] w_m7;

    always_comb begin
        case (funct3)
            F3_SB:   w_base = 4'b0001;
            F3_SH:   w_base = 4'b0011;
            F3_SW:   w_base = 4'b1111;
            default: w_base = 4'b0000;
        endcase
    end

    // Bits [6:4] of the shifted mask are the lanes spilling into the next word
    assign w_m7 = {3'b000, w_base} << off;

    always_comb begin
        case (off)
            2'd0:    wdata = data;
            2'd1:    wdata = {data[23:0], data[31:24]};
            2'd2:    wdata = {data[15:0], data[31:16]};
            default: wdata = {data[7:0],  data[31:8]};
        endcase
    end

    assign wrbits0    = expand_mask(w_m7[3:0]);
    assign wrbits1    = expand_mask({1'b0, w_m7[6:4]});
    assign misaligned = |w_m7[6:4];

endmodule

`default_nettype wire

// File: rtl/st_ctrl.sv
// ============================================================================
// Module      : st_ctrl
// Description : Store-access sequencer: decodes SB/SH/SW, drives the data
//               memory req/ack port, reports done or fault. Optional macro
//               ST_MISALIGN_SPLIT_EN splits misaligned stores in two words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module st_ctrl
    import st_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_ir,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_wrbits
);

`ifdef ST_MISALIGN_SPLIT_EN
    localparam bit c_split_en = 1'b1;
`else
    localparam bit c_split_en = 1'b0;
`endif

    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

    st_state_e   r_state;
    st_state_e   w_state_next;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_fault_code_next;
    logic [15:0] r_tmo_cnt;
    logic [31:0] r_addr0;
    logic [31:0] r_wdata;
    logic [31:0] r_wrbits0;
    logic [31:0] r_wrbits1;
    logic        r_split;

    logic [31:0] w_lane_wdata;
    logic [31:0] w_lane_wrbits0;
    logic [31:0] w_lane_wrbits1;
    logic        w_lane_mis;
    logic        w_legal;
    logic        w_accept;
    logic [31:0] w_addr1;
    logic        w_unused_ir;

    st_lane_align u_lane_align (
        .funct3     (req_ir[14:12]),
        .off        (req_addr[1:0]),
        .data       (req_data),
        .wdata      (w_lane_wdata),
        .wrbits0    (w_lane_wrbits0),
        .wrbits1    (w_lane_wrbits1),
        .misaligned (w_lane_mis)
    );

    assign w_legal = (req_ir[6:0] == OPC_STORE) &&
                     ((req_ir[14:12] == F3_SB) || (req_ir[14:12] == F3_SH) ||
                      (req_ir[14:12] == F3_SW));
    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_addr1     = r_addr0 + 32'd4;
    assign w_unused_ir = ^{req_ir[31:15], req_ir[11:7]};

    always_comb begin
        w_state_next      = r_state;
        w_fault_code_next = r_fault_code;
        req_ready         = 1'b0;
        done              = 1'b0;
        fault             = 1'b0;
        fault_code        = FLT_NONE;
        mem_req           = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        mem_wrbits        = '0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!w_legal) begin
                        w_state_next      = FAULT;
                        w_fault_code_next = FLT_ILLEGAL;
                    end else if (w_lane_mis && !c_split_en) begin
                        w_state_next      = FAULT;
                        w_fault_code_next = FLT_MISALIGN;
                    end else begin
                        w_state_next = ACC0;
                    end
                end
            end
            ACC0: begin
                mem_req    = 1'b1;
                mem_addr   = r_addr0;
                mem_wdata  = r_wdata;
                mem_wrbits = r_wrbits0;
                // An ack on the final allowed cycle beats the timeout
                if (mem_ack) begin
                    w_state_next = (c_split_en && r_split) ? ACC1 : DONE;
                end else if (r_tmo_cnt == c_to_last) begin
                    w_state_next      = FAULT;
                    w_fault_code_next = FLT_TIMEOUT;
                end
            end
            ACC1: begin
                mem_req    = 1'b1;
                mem_addr   = w_addr1;
                mem_wdata  = r_wdata;
                mem_wrbits = r_wrbits1;
                if (mem_ack) begin
                    w_state_next = DONE;
                end else if (r_tmo_cnt == c_to_last) begin
                    w_state_next      = FAULT;
                    w_fault_code_next = FLT_TIMEOUT;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            FAULT: begin
                fault        = 1'b1;
                fault_code   = r_fault_code;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fault_code <= FLT_NONE;
            r_tmo_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_fault_code <= w_fault_code_next;
            // Any state change (including ACC0 -> ACC1) restarts the count
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (mem_req && !mem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr0   <= '0;
            r_wdata   <= '0;
            r_wrbits0 <= '0;
            r_wrbits1 <= '0;
            r_split   <= 1'b0;
        end else if (w_accept) begin
            r_addr0   <= {req_addr[31:2], 2'b00};
            r_wdata   <= w_lane_wdata;
            r_wrbits0 <= w_lane_wrbits0;
            r_wrbits1 <= w_lane_wrbits1;
            r_split   <= w_lane_mis;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_st_ctrl.sv
// ============================================================================
// Module      : tb_st_ctrl
// Description : Self-checking bench for st_ctrl with an access scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_st_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wrbits;
    } acc_t;

    localparam int unsigned TMO    = 4;
    localparam logic [6:0]  OPC_ST = 7'b0100011;
    localparam logic [6:0]  OPC_LD = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_ir = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wrbits;

    st_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ir     (req_ir),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wrbits (mem_wrbits)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    acc_t exp_q[$];
    acc_t obs_q[$];
    int   obs_mreq_cyc;
    int   obs_end_cyc;
    bit   obs_done, obs_fault, obs_hung, obs_unstable, obs_dirty, obs_ready_after;
    logic [1:0] obs_code;

    function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r        = $urandom;
        r[14:12] = f3;
        r[6:0]   = opc;
        return r;
    endfunction

    // Reference: place each stored byte into its lane, word by word
    task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output logic [1:0] code);
        logic [31:0] wd, wb0, wb1, base;
        int nb, p;
        bit mis;
        code = 2'b00; wd = '0; wb0 = '0; wb1 = '0; mis = 1'b0;
        base = addr & 32'hFFFF_FFFC;
        for (int l = 0; l < 4; l++) wd[8*l +: 8] = data[8*((l + 4 - int'(addr[1:0])) % 4) +: 8];
        nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int b = 0; b < nb; b++) begin
            p = int'(addr[1:0]) + b;
            if (p < 4) wb0[8*p +: 8] = 8'hFF;
            else begin wb1[8*(p-4) +: 8] = 8'hFF; mis = 1'b1; end
        end
        if (opc != OPC_ST || f3 > 3'd2) code = 2'b01;
        else if (mis) begin
`ifdef ST_MISALIGN_SPLIT_EN
            exp_q.push_back('{base, wd, wb0});
            exp_q.push_back('{base + 32'd4, wd, wb1});
`else
            code = 2'b10;
`endif
        end else exp_q.push_back('{base, wd, wb0});
    endtask

    // Drives one request and records what the DUT does; ack_lat < 0 never acks
    task automatic run_req(input logic [31:0] ir, input logic [31:0] addr,
                           input logic [31:0] data, input int ack_lat);
        acc_t cur;
        int k, cyc;
        bit fin;
        obs_mreq_cyc = 0; obs_end_cyc = 0; obs_done = 0; obs_fault = 0; obs_hung = 0;
        obs_unstable = 0; obs_dirty = 0; obs_code = 2'b00; obs_ready_after = 0;
        cur = '0; k = 0; cyc = 0; fin = 0;
        req_valid = 1'b1; req_ir = ir; req_addr = addr; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0; req_ir = $urandom; req_addr = $urandom; req_data = $urandom;
        while (!fin && cyc < 40) begin
            @(negedge clk); cyc++;
            if (mem_req) begin
                if (k == 0) cur = '{mem_addr, mem_wdata, mem_wrbits};
                else if (cur !== acc_t'({mem_addr, mem_wdata, mem_wrbits})) obs_unstable = 1;
                obs_mreq_cyc++;
                mem_ack = (ack_lat >= 0 && k >= ack_lat);
                if (mem_ack) begin obs_q.push_back(cur); k = 0; end
                else k++;
            end else begin
                mem_ack = 1'b0; k = 0;
                if ((mem_addr | mem_wdata | mem_wrbits) != 32'd0) obs_dirty = 1;
            end
            if (done)  begin obs_done = 1; obs_end_cyc = cyc; fin = 1; end
            if (fault) begin obs_fault = 1; obs_code = fault_code; obs_end_cyc = cyc; fin = 1; end
        end
        if (!fin) obs_hung = 1;
        @(negedge clk);
        mem_ack = 1'b0;
        obs_ready_after = req_ready;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, done, fault, fault_code, mem_req} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctl got %b want 100000", {req_ready, done, fault, fault_code, mem_req});
        end
        checks++;
        if ((mem_addr | mem_wdata | mem_wrbits) !== 32'd0) begin
            errors++; $display("FAIL reset_mem got %h/%h/%h want 0", mem_addr, mem_wdata, mem_wrbits);
        end
    endtask

    task automatic test_sb;
        acc_t e, a;
        exp_q.push_back('{32'h0000_1000, 32'h7812_3456, 32'hFF00_0000});
        run_req(mk_ir(OPC_ST, 3'b000), 32'h0000_1003, 32'h1234_5678, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL sb_acc missing want %h", e); end
            else begin
                a = obs_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL sb_acc got %h want %h", a, e); end
            end
        end
        checks++;
        if ({obs_done, obs_fault, obs_end_cyc} !== {1'b1, 1'b0, 32'd2}) begin
            errors++; $display("FAIL sb_latency got done=%0d fault=%0d cyc=%0d want 1 0 2", obs_done, obs_fault, obs_end_cyc);
        end
        checks++;
        if (obs_mreq_cyc !== 1 || obs_ready_after !== 1'b1 || obs_dirty) begin
            errors++; $display("FAIL sb_shape got mreq=%0d ready=%0d dirty=%0d want 1 1 0", obs_mreq_cyc, obs_ready_after, obs_dirty);
        end
        obs_q.delete();
    endtask

    task automatic test_sh_wait;
        acc_t e, a;
        exp_q.push_back('{32'h0000_2000, 32'hCCDD_AABB, 32'hFFFF_0000});
        // Ack arrives exactly when the timeout count hits its limit
        run_req(mk_ir(OPC_ST, 3'b001), 32'h0000_2002, 32'hAABB_CCDD, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL sh_acc missing want %h", e); end
            else begin
                a = obs_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL sh_acc got %h want %h", a, e); end
            end
        end
        checks++;
        if (obs_mreq_cyc !== 4 || obs_unstable) begin
            errors++; $display("FAIL sh_hold got mreq=%0d unstable=%0d want 4 0", obs_mreq_cyc, obs_unstable);
        end
        checks++;
        if ({obs_done, obs_fault} !== 2'b10) begin
            errors++; $display("FAIL sh_end got done=%0d fault=%0d code=%b want done", obs_done, obs_fault, obs_code);
        end
        obs_q.delete();
    endtask

    task automatic test_misalign;
        acc_t e, a;
        logic [1:0] ecode;
        logic [31:0] wrap_addr [2];
        logic [2:0]  wrap_f3 [2];
        wrap_addr[0] = 32'hFFFF_FFFF; wrap_f3[0] = 3'b001;
        wrap_addr[1] = 32'hFFFF_FFFD; wrap_f3[1] = 3'b010;
`ifdef ST_MISALIGN_SPLIT_EN
        exp_q.push_back('{32'h0000_3000, 32'h2233_4411, 32'hFFFF_FF00});
        exp_q.push_back('{32'h0000_3004, 32'h2233_4411, 32'h0000_00FF});
        ecode = 2'b00;
`else
        ecode = 2'b10;
`endif
        for (int t = 0; t < 3; t++) begin
            if (t == 0) run_req(mk_ir(OPC_ST, 3'b010), 32'h0000_3001, 32'h1122_3344, 0);
            else begin
                model(OPC_ST, wrap_f3[t-1], wrap_addr[t-1], 32'hA1B2_C3D4, ecode);
                run_req(mk_ir(OPC_ST, wrap_f3[t-1]), wrap_addr[t-1], 32'hA1B2_C3D4, t - 1);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); checks++;
                if (obs_q.size() == 0) begin errors++; $display("FAIL mis_acc%0d missing want %h", t, e); end
                else begin
                    a = obs_q.pop_front();
                    if (a !== e) begin errors++; $display("FAIL mis_acc%0d got %h want %h", t, a, e); end
                end
            end
            checks++;
            if ({obs_done, obs_fault, obs_code} !== {ecode == 2'b00, ecode != 2'b00, ecode}) begin
                errors++; $display("FAIL mis_end%0d got done=%0d fault=%0d code=%b want code %b", t, obs_done, obs_fault, obs_code, ecode);
            end
            checks++;
            if (obs_q.size() != 0 || (ecode != 2'b00 && obs_mreq_cyc != 0) || obs_dirty) begin
                errors++; $display("FAIL mis_bus%0d got extra=%0d mreq=%0d dirty=%0d want none", t, obs_q.size(), obs_mreq_cyc, obs_dirty);
            end
            obs_q.delete();
        end
    endtask

    task automatic test_illegal;
        logic [31:0] irs [2];
        irs[0] = mk_ir(OPC_LD, 3'b010);
        irs[1] = mk_ir(OPC_ST, 3'b011);
        for (int t = 0; t < 2; t++) begin
            run_req(irs[t], 32'h0000_4000, 32'hDEAD_BEEF, 0);
            checks++;
            if ({obs_done, obs_fault, obs_code, obs_end_cyc} !== {1'b0, 1'b1, 2'b01, 32'd1}) begin
                errors++; $display("FAIL illegal%0d got done=%0d fault=%0d code=%b cyc=%0d want 0 1 01 1", t, obs_done, obs_fault, obs_code, obs_end_cyc);
            end
            checks++;
            if (obs_mreq_cyc != 0 || obs_q.size() != 0 || obs_dirty) begin
                errors++; $display("FAIL illegal_bus%0d got mreq=%0d acc=%0d want 0 0", t, obs_mreq_cyc, obs_q.size());
            end
            obs_q.delete();
        end
    endtask

    task automatic test_timeout;
        run_req(mk_ir(OPC_ST, 3'b010), 32'h0000_5000, 32'h0BAD_F00D, -1);
        checks++;
        if (obs_mreq_cyc !== int'(TMO) || obs_unstable) begin
            errors++; $display("FAIL tmo_req got mreq=%0d unstable=%0d want %0d 0", obs_mreq_cyc, obs_unstable, TMO);
        end
        checks++;
        if ({obs_done, obs_fault, obs_code} !== 4'b0111 || obs_end_cyc != int'(TMO) + 1) begin
            errors++; $display("FAIL tmo_end got done=%0d fault=%0d code=%b cyc=%0d want 0 1 11 %0d", obs_done, obs_fault, obs_code, obs_end_cyc, TMO + 1);
        end
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || obs_q.size() != 0) begin
            errors++; $display("FAIL tmo_after got mem_req=%b ready=%b acc=%0d want 0 1 0", mem_req, req_ready, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_abort;
        acc_t e, a;
        req_valid = 1'b1; req_ir = mk_ir(OPC_ST, 3'b010); req_addr = 32'h0000_0020; req_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre got mem_req=%b want 1", mem_req); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req, req_ready, done, fault} !== 4'b0100) begin
                errors++; $display("FAIL abort_post%0d got req/rdy/done/fault=%b want 0100", c, {mem_req, req_ready, done, fault});
            end
        end
        exp_q.push_back('{32'h0000_0010, 32'hCAFE_0123, 32'hFFFF_FFFF});
        run_req(mk_ir(OPC_ST, 3'b010), 32'h0000_0010, 32'hCAFE_0123, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL abort_sw missing want %h", e); end
            else begin
                a = obs_q.pop_front();
                if (a !== e) begin errors++; $display("FAIL abort_sw got %h want %h", a, e); end
            end
        end
        checks++;
        if ({obs_done, obs_fault} !== 2'b10) begin
            errors++; $display("FAIL abort_sw_end got done=%0d fault=%0d want 1 0", obs_done, obs_fault);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        acc_t e, a;
        logic [1:0]  ecode;
        logic [31:0] addr, data;
        logic [2:0]  f3;
        for (int i = 0; i < 12; i++) begin
            addr = $urandom; addr[1:0] = 2'(i % 4);
            data = $urandom;
            f3   = 3'(i / 4);
            model(OPC_ST, f3, addr, data, ecode);
            run_req(mk_ir(OPC_ST, f3), addr, data, int'($urandom_range(0, 2)));
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); checks++;
                if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_acc%0d missing want %h", i, e); end
                else begin
                    a = obs_q.pop_front();
                    if (a !== e) begin errors++; $display("FAIL b2b_acc%0d got %h want %h", i, a, e); end
                end
            end
            checks++;
            if ({obs_done, obs_fault, obs_code} !== {ecode == 2'b00, ecode != 2'b00, ecode} || obs_q.size() != 0 || obs_hung) begin
                errors++; $display("FAIL b2b_end%0d got done=%0d fault=%0d code=%b extra=%0d hung=%0d want code %b", i, obs_done, obs_fault, obs_code, obs_q.size(), obs_hung, ecode);
            end
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_wait();
        test_misalign();
        test_illegal();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time limit want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
